// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter.
// Used by irq_arbiter and irq_edge_detect.
package irq_pkg;

  localparam int NUM_SRC = 4;
  localparam int VEC_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE,
    COOL
  } state_t;

  // First eligible source at or after start, wrapping modulo NUM_SRC.
  function automatic logic [VEC_W-1:0] pickSrc(
    input logic [NUM_SRC-1:0] elig,
    input logic [VEC_W-1:0]   start
  );
    logic [VEC_W-1:0] idx;
    logic [VEC_W-1:0] win;
    logic             found;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = start + VEC_W'(k);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector on level interrupt lines.
// A registered copy of the input marks 0->1 transitions.
module irq_edge_detect
  import irq_pkg::*;
#(
  parameter int W = NUM_SRC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] levelQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) levelQ <= '0;
    else        levelQ <= level;
  end

  assign rise = level & ~levelQ;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches edges, grants one source at a time.
// Define IRQ_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module irq_arbiter #(
  parameter logic [31:0] IVT_BASE = 32'h0000_0000,
  parameter int          NUM_SRC  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic                      mask_we,
  input  logic [NUM_SRC-1:0]        mask_wdata,
  input  logic                      stall,
  input  logic                      irq_ack,
  input  logic                      irq_done,
  output logic                      irq_req,
  output logic [irq_pkg::VEC_W-1:0] irq_vec,
  output logic [31:0]               ivt_addr,
  output logic [NUM_SRC-1:0]        pending,
  output logic                      busy
);

  import irq_pkg::*;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clrVec;
  logic [VEC_W-1:0]   start;
  logic [VEC_W-1:0]   winner;
  logic               ackHit;

  irq_edge_detect #(
    .W(NUM_SRC)
  ) uEdge (
    .clk  (clk),
    .rst_n(rst_n),
    .level(irq_src),
    .rise (rise)
  );

  assign elig   = pending & ~mask;
  assign ackHit = (state == REQ) && irq_ack;
  assign clrVec = ackHit ? (NUM_SRC'(1) << irq_vec) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [VEC_W-1:0] rrPtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rrPtr <= '0;
    else if (ackHit) rrPtr <= irq_vec + 1'b1;
  end

  assign start = rrPtr;
`else
  assign start = '0;
`endif

  assign winner = pickSrc(elig, start);

  // A new edge on a bit being acked keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clrVec) | rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq_req  <= 1'b0;
      irq_vec  <= '0;
      ivt_addr <= IVT_BASE;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|elig && !stall) begin
            state    <= REQ;
            irq_req  <= 1'b1;
            irq_vec  <= winner;
            ivt_addr <= IVT_BASE + 32'(winner);
            busy     <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= COOL;
        end
        COOL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
